// File: rtl/game_reaction_multi.sv
// -----------------------------------------------------------------------------
// game_reaction_multi
//
// This is a multi-round reaction game with NUM_BTNS buttons. Each round runs in
// this order:
//   WAIT   : the display is blank. The wait length is BASE_DELAY + rnd*STEP_DELAY.
//   SHOW   : a target from 1 to NUM_BTNS is shown, and the round waits for a press.
//   RESULT : the round result (right, wrong/miss, or early) is held for a while.
// After ROUNDS rounds the match ends in OVER. Any press in OVER starts a new
// match.
//
// Optional feature: define GAME_BEST_TIME_EN to track the fastest correct
// reaction time of the match on best_time. When it is not defined, best_time
// is tied to 0.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   btn         synchronised, debounced buttons, active-high; btn[i] = target i+1
//   rnd         4-bit random digit
//   value       display code: 0 blank, 1..9 target, 10 right, 11 wrong/miss,
//               12 early, 13 over
//   score       number of correct rounds in this match (saturates at 15)
//   react_time  SHOW cycles counted up to the last correct press
//   round_done  one-cycle pulse on every entry to RESULT
//   game_over   high while in OVER
//   best_time   fastest correct react_time in this match (all ones = none yet)
// -----------------------------------------------------------------------------
module game_reaction_multi #(
  parameter int NUM_BTNS    = 4,
  parameter int CNT_W       = 28,
  parameter int BASE_DELAY  = 10_000_000,
  parameter int STEP_DELAY  = 10_000_000,
  parameter int RESULT_TIME = 10_000_000,
  parameter int TIMEOUT     = 50_000_000,
  parameter int ROUNDS      = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic [3:0]          rnd,
  output logic [3:0]          value,
  output logic [3:0]          score,
  output logic [CNT_W-1:0]    react_time,
  output logic                round_done,
  output logic                game_over,
  output logic [CNT_W-1:0]    best_time
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SHOW   = 2'd1,
    S_RESULT = 2'd2,
    S_OVER   = 2'd3
  } state_e;

  localparam logic [3:0]       V_BLANK    = 4'd0;
  localparam logic [3:0]       V_RIGHT    = 4'd10;
  localparam logic [3:0]       V_WRONG    = 4'd11;
  localparam logic [3:0]       V_EARLY    = 4'd12;
  localparam logic [3:0]       V_OVER     = 4'd13;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] RES_LAST_C = CNT_W'(RESULT_TIME - 1);
  localparam logic [3:0]       LAST_RND_C = 4'(ROUNDS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    thr_q, thr_d;
  logic                latch_q, latch_d;
  logic [NUM_BTNS-1:0] btn_q;
  logic [NUM_BTNS-1:0] tmask_q, tmask_d;
  logic [3:0]          round_q, round_d;
  logic [3:0]          value_q, value_d;
  logic [3:0]          score_q, score_d;
  logic [CNT_W-1:0]    react_q, react_d;
  logic                round_done_q, round_done_d;
  logic                game_over_q, game_over_d;

  logic [NUM_BTNS-1:0] press_w;
  logic                any_press;
  logic [CNT_W-1:0]    thr_calc;
  logic [CNT_W-1:0]    thr_now;
  logic [CNT_W-1:0]    cnt_inc;
  logic [3:0]          tgt_calc;
  logic [NUM_BTNS-1:0] mask_calc;
  logic                correct_press;
  logic                leave_over;

  // Only rising edges count as presses, so a held button never fires again.
  assign press_w   = btn & ~btn_q;
  assign any_press = |press_w;

  assign thr_calc  = CNT_W'(BASE_DELAY) + CNT_W'(rnd) * CNT_W'(STEP_DELAY);
  // latch_q marks the first WAIT cycle. On that cycle the register does not
  // hold the new threshold yet, so the freshly computed value is compared.
  assign thr_now   = latch_q ? thr_calc : thr_q;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  assign tgt_calc  = 4'((32'(rnd) % NUM_BTNS) + 1);
  assign mask_calc = {{(NUM_BTNS-1){1'b0}}, 1'b1} << (tgt_calc - 4'd1);

  // The press must be equal to the one-hot target mask. This rejects both a
  // wrong button and several buttons rising in the same cycle.
  assign correct_press = (state_q == S_SHOW) && any_press && (press_w == tmask_q);
  assign leave_over    = (state_q == S_OVER) && any_press;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_inc;
    thr_d        = thr_now;
    latch_d      = 1'b0;
    tmask_d      = tmask_q;
    round_d      = round_q;
    value_d      = value_q;
    score_d      = score_q;
    react_d      = react_q;
    round_done_d = 1'b0;
    game_over_d  = game_over_q;

    case (state_q)
      S_WAIT: begin
        value_d = V_BLANK;
        if (any_press) begin
          state_d      = S_RESULT;
          cnt_d        = '0;
          value_d      = V_EARLY;
          round_done_d = 1'b1;
        end else if (cnt_q == thr_now) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          tmask_d = mask_calc;
          value_d = tgt_calc;
        end
      end

      S_SHOW: begin
        if (any_press) begin
          state_d      = S_RESULT;
          cnt_d        = '0;
          round_done_d = 1'b1;
          if (correct_press) begin
            value_d = V_RIGHT;
            score_d = (score_q == 4'hF) ? score_q : score_q + 4'd1;
            react_d = cnt_q;
          end else begin
            value_d = V_WRONG;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d      = S_RESULT;
          cnt_d        = '0;
          value_d      = V_WRONG;
          round_done_d = 1'b1;
        end
      end

      S_RESULT: begin
        if (cnt_q == RES_LAST_C) begin
          cnt_d   = '0;
          round_d = round_q + 4'd1;
          if (round_q == LAST_RND_C) begin
            state_d     = S_OVER;
            value_d     = V_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            latch_d = 1'b1;
            value_d = V_BLANK;
          end
        end
      end

      S_OVER: begin
        value_d = V_OVER;
        if (leave_over) begin
          state_d     = S_WAIT;
          cnt_d       = '0;
          latch_d     = 1'b1;
          value_d     = V_BLANK;
          game_over_d = 1'b0;
          score_d     = '0;
          react_d     = '0;
          round_d     = '0;
        end
      end

      default: begin
        state_d     = S_WAIT;
        cnt_d       = '0;
        latch_d     = 1'b1;
        value_d     = V_BLANK;
        game_over_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      thr_q        <= '0;
      latch_q      <= 1'b1;
      btn_q        <= '0;
      tmask_q      <= '0;
      round_q      <= '0;
      value_q      <= V_BLANK;
      score_q      <= '0;
      react_q      <= '0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      thr_q        <= thr_d;
      latch_q      <= latch_d;
      btn_q        <= btn;
      tmask_q      <= tmask_d;
      round_q      <= round_d;
      value_q      <= value_d;
      score_q      <= score_d;
      react_q      <= react_d;
      round_done_q <= round_done_d;
      game_over_q  <= game_over_d;
    end
  end

`ifdef GAME_BEST_TIME_EN
  logic [CNT_W-1:0] best_q, best_d;

  // On a correct press the new react_time is cnt_q, so cnt_q is compared directly.
  always_comb begin
    best_d = best_q;
    if (leave_over) begin
      best_d = '1;
    end else if (correct_press && (cnt_q < best_q)) begin
      best_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_q <= '1;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_time = best_q;
`else
  assign best_time = '0;
`endif

  assign value      = value_q;
  assign score      = score_q;
  assign react_time = react_q;
  assign round_done = round_done_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_reaction_multi.sv
module tb_game_reaction_multi;

  localparam int NB   = 4;
  localparam int CW   = 8;
  localparam int BASE = 10;
  localparam int STEP = 2;
  localparam int RT   = 5;
  localparam int TO   = 20;
  localparam int NR   = 3;

`ifdef GAME_BEST_TIME_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] btn;
  logic [3:0]    rnd;
  logic [3:0]    value;
  logic [3:0]    score;
  logic [CW-1:0] react_time;
  logic          round_done;
  logic          game_over;
  logic [CW-1:0] best_time;

  always #5 clk = ~clk;

  game_reaction_multi #(
    .NUM_BTNS   (NB),
    .CNT_W      (CW),
    .BASE_DELAY (BASE),
    .STEP_DELAY (STEP),
    .RESULT_TIME(RT),
    .TIMEOUT    (TO),
    .ROUNDS     (NR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn       (btn),
    .rnd       (rnd),
    .value     (value),
    .score     (score),
    .react_time(react_time),
    .round_done(round_done),
    .game_over (game_over),
    .best_time (best_time)
  );

  typedef enum int {K_NONE, K_PRESS, K_EARLY} kind_e;

  typedef struct {
    int         rnd;
    kind_e      kind;
    int         dly;
    logic [3:0] pat;
    logic [3:0] hold;
    int         e_val;
    int         e_score;
    int         e_react;
    int         e_exit;
    int         e_best;
  } vec_t;

  typedef struct {
    int val;
    int score;
    int react;
  } exp_t;

  vec_t tbl[13];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_react"}, int'(react_time), 0);
    chk({tag, "_round_done"}, int'(round_done), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_best"}, int'(best_time), BEST_EN ? 255 : 0);
  endtask

  task automatic play_round(input vec_t v);
    int         n;
    int         res;
    logic [3:0] tgt;
    exp_t       e;
    rnd = 4'(v.rnd);
    tgt = 4'(v.rnd % NB + 1);
    if (v.kind == K_EARLY) begin
      repeat (v.dly) tick();
      chk("early_no_show", int'(value), 0);
      btn = v.pat;
    end else begin
      n = 0;
      while (value == 4'd0 && n < 200) begin
        tick();
        n++;
      end
      chk("wait_len", n, BASE + v.rnd * STEP + 1);
      chk("show_target", int'(value), int'(tgt));
      if (v.kind == K_PRESS) begin
        repeat (v.dly) tick();
        btn = v.pat;
      end
    end
    e = '{v.e_val, v.e_score, v.e_react};
    sbq.push_back(e);

    n = 0;
    while (round_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("decide_latency", n, (v.kind == K_NONE) ? TO + 1 : 1);
    btn = v.hold;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk("result_value", int'(value), e.val);
      chk("result_score", int'(score), e.score);
      chk("result_react", int'(react_time), e.react);
    end

    res = int'(value);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("round_done_pulse", int'(round_done), 0);
    end while (int'(value) == res && n < 50);
    chk("result_len", n, RT);
    chk("exit_value", int'(value), v.e_exit);
    chk("exit_game_over", int'(game_over), (v.e_exit == 13) ? 1 : 0);
  endtask

  task automatic leave_over(input int sc, input int rt, input int bt);
    chk("over_value", int'(value), 13);
    chk("over_game_over", int'(game_over), 1);
    chk("over_score", int'(score), sc);
    chk("over_react", int'(react_time), rt);
    chk("over_best", int'(best_time), BEST_EN ? bt : 0);
    repeat (3) tick();
    chk("over_value_held", int'(value), 13);
    chk("over_score_held", int'(score), sc);
    btn = 4'b1000;
    tick();
    btn = 4'b0000;
    chk_idle_outputs("new_match");
  endtask

  task automatic reset_mid_show();
    int n;
    rnd = 4'd4;
    n = 0;
    while (value == 4'd0 && n < 200) begin
      tick();
      n++;
    end
    chk("pre_reset_target", int'(value), 1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    tick();
    tick();
    chk("reset_hold_value", int'(value), 0);
    reset_n = 1'b1;
  endtask

  initial begin
    //          rnd kind     dly pat      hold     val sc rt exit best
    tbl[0]  = '{3,  K_NONE,  0, 4'b0000, 4'b0000, 11, 0, 0, 0,  0};
    tbl[1]  = '{1,  K_PRESS, 6, 4'b0010, 4'b0000, 10, 1, 6, 0,  0};
    tbl[2]  = '{5,  K_EARLY, 4, 4'b0001, 4'b0000, 12, 1, 6, 13, 6};
    tbl[3]  = '{2,  K_PRESS, 3, 4'b0110, 4'b0100, 11, 0, 0, 0,  0};
    tbl[4]  = '{6,  K_NONE,  0, 4'b0000, 4'b0000, 11, 0, 0, 0,  0};
    tbl[5]  = '{0,  K_PRESS, 2, 4'b0001, 4'b0000, 10, 1, 2, 13, 2};
    tbl[6]  = '{7,  K_PRESS, 9, 4'b1000, 4'b0000, 10, 1, 9, 0,  0};
    tbl[7]  = '{4,  K_PRESS, 4, 4'b0001, 4'b0000, 10, 2, 4, 0,  0};
    tbl[8]  = '{9,  K_PRESS, 7, 4'b0010, 4'b0000, 10, 3, 7, 13, 4};
    tbl[9]  = '{11, K_PRESS, 5, 4'b1000, 4'b0000, 10, 1, 5, 0,  0};
    tbl[10] = '{15, K_PRESS, 1, 4'b0100, 4'b0000, 11, 0, 0, 0,  0};
    tbl[11] = '{8,  K_PRESS, 0, 4'b0001, 4'b0000, 10, 1, 0, 0,  0};
    tbl[12] = '{13, K_NONE,  0, 4'b0000, 4'b0000, 11, 1, 0, 13, 0};

    reset_n = 1'b0;
    btn     = '0;
    rnd     = 4'd3;
    repeat (3) tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      play_round(tbl[i]);
      if (tbl[i].e_exit == 13) leave_over(tbl[i].e_score, tbl[i].e_react, tbl[i].e_best);
      if (i == 9) reset_mid_show();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
